// File: rtl/iq_sample_reader.sv
// iq_sample_reader: reassembles interleaved I/Q words from the sample RAM into pairs for the DSP path
// Ports: dsp_clk/rst (sync, active-high); wr_strobe counts committed writer words;
// read_en/read_addr/read_data drive the synchronous sample RAM (1-cycle read latency);
// inphase_out/quad_out/sample_valid/sample_ready present one pair per handshake;
// overrun is sticky until clear_overrun; fill_level counts unread words (0..DEPTH).
module iq_sample_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              dsp_clk,
  input  logic              rst,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_en,
  output logic [ADDR_W:0]   read_addr,
  output logic [DATA_W-1:0] inphase_out,
  output logic [DATA_W-1:0] quad_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  input  logic              clear_overrun,
  output logic              overrun,
  output logic [ADDR_W:0]   fill_level
);
  typedef enum logic [2:0] {IDLE, RD_I, RD_Q, CAP_Q, HOLD} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_fill;
  logic [ADDR_W:0]     r_addr;
  logic                r_read_en;
  logic                r_valid;
  logic                r_ovr;
  logic [DATA_W-1:0]   r_i;
  logic [DATA_W-1:0]   r_i_out;
  logic [DATA_W-1:0]   r_q_out;
  logic                w_full;
  logic                w_ovf;
  logic                w_avail;
  logic [ADDR_W:0]     w_fill_nxt;
  always_comb begin
    w_full     = r_fill == (ADDR_W+1)'(DEPTH);
    w_ovf      = wr_strobe && !r_read_en && w_full;
    w_avail    = r_fill >= (ADDR_W+1)'(2);
    w_fill_nxt = (wr_strobe && !r_read_en && !w_full) ? r_fill + 1'b1 :
                 (!wr_strobe && r_read_en)            ? r_fill - 1'b1 : r_fill;
  end
  // Outputs are registered on the transition into a state, so read_en/read_addr
  // are valid during the RD_I and RD_Q cycles themselves; rd_ptr is a power-of-two
  // counter, so its natural rollover is the DEPTH-1 -> 0 wrap.
  always_ff @(posedge dsp_clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_fill    <= '0;
      r_addr    <= '0;
      r_read_en <= 1'b0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
      r_i       <= '0;
      r_i_out   <= '0;
      r_q_out   <= '0;
    end else begin
      r_fill <= w_fill_nxt;
      r_ovr  <= w_ovf || (r_ovr && !clear_overrun);
      case (r_state)
        IDLE: if (w_avail && !r_valid) begin
          r_state   <= RD_I;
          r_read_en <= 1'b1;
          r_addr    <= {1'b0, r_ptr};
          r_ptr     <= r_ptr + 1'b1;
        end
        RD_I: begin
          r_state   <= RD_Q;
          r_read_en <= 1'b1;
          r_addr    <= {1'b0, r_ptr};
          r_ptr     <= r_ptr + 1'b1;
        end
        RD_Q: begin
          r_state   <= CAP_Q;
          r_read_en <= 1'b0;
          r_i       <= read_data;
        end
        CAP_Q: begin
          r_state <= HOLD;
          r_i_out <= r_i;
          r_q_out <= read_data;
          r_valid <= 1'b1;
        end
        HOLD: if (sample_ready) begin
          r_valid <= 1'b0;
          if (w_avail) begin
            r_state   <= RD_I;
            r_read_en <= 1'b1;
            r_addr    <= {1'b0, r_ptr};
            r_ptr     <= r_ptr + 1'b1;
          end else
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign read_en      = r_read_en;
  assign read_addr    = r_addr;
  assign inphase_out  = r_i_out;
  assign quad_out     = r_q_out;
  assign sample_valid = r_valid;
  assign overrun      = r_ovr;
  assign fill_level   = r_fill;
endmodule

// File: tb/tb_iq_sample_reader.sv
// tb_iq_sample_reader: scoreboard bench for iq_sample_reader with a synchronous RAM model
module tb_iq_sample_reader;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int DEPTH = 1 << AW;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_strobe = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          read_en;
  logic [AW:0]   read_addr;
  logic [DW-1:0] inphase_out;
  logic [DW-1:0] quad_out;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          clear_overrun = 1'b0;
  logic          overrun;
  logic [AW:0]   fill_level;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            wr_idx = 0;
  int            exp_addr = 0;
  int            rd_total = 0;
  iq_sample_reader dut (
    .dsp_clk(clk), .rst(rst), .wr_strobe(wr_strobe), .read_data(read_data),
    .read_en(read_en), .read_addr(read_addr), .inphase_out(inphase_out),
    .quad_out(quad_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .clear_overrun(clear_overrun), .overrun(overrun), .fill_level(fill_level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (read_en) read_data <= mem[read_addr[AW-1:0]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [DW-1:0] v);
    mem[wr_idx] = v;
    q.push_back(v);
    wr_idx = (wr_idx + 1) % DEPTH;
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    wr_idx = 0;
    exp_addr = 0;
    rd_total = 0;
    tick();
    rst = 1'b0;
  endtask
  task automatic wait_valid(input int n, input string tag);
    int k = 0;
    while (!sample_valid && k < n) begin
      tick();
      k++;
    end
    chk(tag, 32'(sample_valid), 1);
  endtask
  always @(negedge clk) if (!rst) begin
    if (read_en) begin
      chk("read_addr", 32'(read_addr), exp_addr);
      exp_addr = (exp_addr + 1) % DEPTH;
      rd_total++;
    end
    if (sample_valid && sample_ready) begin
      if (q.size() < 2) chk("sb_underflow", q.size(), 2);
      else begin
        chk("inphase_out", 32'(inphase_out), 32'(q.pop_front()));
        chk("quad_out", 32'(quad_out), 32'(q.pop_front()));
      end
    end
  end
  initial begin
    int k;
    tick();
    do_reset();
    tick();
    chk("rst_read_en", 32'(read_en), 0);
    chk("rst_read_addr", 32'(read_addr), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_inphase", 32'(inphase_out), 0);
    chk("rst_quad", 32'(quad_out), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_fill", 32'(fill_level), 0);
    sample_ready = 1'b1;
    put(16'h1234);
    put(16'hABCD);
    wait_valid(10, "t1_valid");
    chk("t1_inphase", 32'(inphase_out), 32'h1234);
    chk("t1_quad", 32'(quad_out), 32'hABCD);
    chk("t1_fill", 32'(fill_level), 0);
    tick();
    chk("t1_valid_clr", 32'(sample_valid), 0);
    chk("t1_hold_i", 32'(inphase_out), 32'h1234);
    sample_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(16'($urandom));
    wait_valid(20, "t2_valid");
    for (int i = 0; i < 10; i++) begin
      chk("t2_no_read", 32'(read_en), 0);
      chk("t2_valid_hold", 32'(sample_valid), 1);
      chk("t2_i_stable", 32'(inphase_out), 32'(q[0]));
      chk("t2_q_stable", 32'(quad_out), 32'(q[1]));
      chk("t2_fill", 32'(fill_level), 2);
      tick();
    end
    sample_ready = 1'b1;
    tick();
    chk("t2_reissue", 32'(read_en), 1);
    k = 0;
    while (q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk("t2_drain", q.size(), 0);
    chk("t2_fill0", 32'(fill_level), 0);
    k = 0;
    while (rd_total < 32772 && k < 80000) begin
      if (fill_level < (AW+1)'(DEPTH - 8)) put(16'($urandom));
      else tick();
      k++;
    end
    chk("wrap_reached", 32'(rd_total >= 32772), 1);
    sample_ready = 1'b0;
    wait_valid(20, "ovr_hold");
    k = 0;
    while (fill_level < (AW+1)'(DEPTH) && k < 200) begin
      put(16'($urandom));
      k++;
    end
    chk("ovr_full", 32'(fill_level), DEPTH);
    chk("ovr_not_yet", 32'(overrun), 0);
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_fill_sat", 32'(fill_level), DEPTH);
    tick();
    chk("ovr_sticky", 32'(overrun), 1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_clear", 32'(overrun), 0);
    clear_overrun = 1'b1;
    wr_strobe = 1'b1;
    tick();
    clear_overrun = 1'b0;
    wr_strobe = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 1);
    chk("ovr_fill_sat2", 32'(fill_level), DEPTH);
    do_reset();
    chk("rst2_overrun", 32'(overrun), 0);
    chk("rst2_fill", 32'(fill_level), 0);
    sample_ready = 1'b1;
    put(16'h1111);
    put(16'h2222);
    k = 0;
    while (!read_en && k < 10) begin
      tick();
      k++;
    end
    chk("t5_rd_i", 32'(read_en), 1);
    put(16'h5555);
    chk("t5_fill_net0", 32'(fill_level), 2);
    chk("t6_in_rdq", 32'(read_en), 1);
    chk("t6_rdq_addr", 32'(read_addr), 1);
    do_reset();
    chk("t6_read_en", 32'(read_en), 0);
    chk("t6_read_addr", 32'(read_addr), 0);
    chk("t6_valid", 32'(sample_valid), 0);
    chk("t6_inphase", 32'(inphase_out), 0);
    chk("t6_quad", 32'(quad_out), 0);
    chk("t6_fill", 32'(fill_level), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_stale", 32'(sample_valid), 0);
      chk("t6_idle", 32'(read_en), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
